// File: rtl/dpll_pkg.sv
// Shared DPLL types: pending-correction state of the I/D counter and the
// half-period reload rule used by the DCO.
package dpll_pkg;

  typedef enum logic [1:0] {
    ID_IDLE,
    ID_INC,
    ID_DEC
  } id_state_t;

  localparam int unsigned ID_HALF_PERIOD_MIN = 2;

  // Half-period length to load at a toggle edge for the given pending state.
  function automatic int unsigned id_reload_len(input id_state_t st,
                                                input int unsigned half);
    int unsigned len;
    len = half;
    case (st)
      ID_INC:  len = half - 1;
      ID_DEC:  len = half + 1;
      default: len = half;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/dpll_id_counter_if.sv
// Request/strobe bundle between the loop filter, the I/D counter and the divider.
interface dpll_id_counter_if;

  logic inc;
  logic dec;
  logic id_out;
  logic id_en;
  logic ovf;

  modport master (
    output inc,
    output dec,
    input  id_out,
    input  id_en,
    input  ovf
  );

  modport slave (
    input  inc,
    input  dec,
    output id_out,
    output id_en,
    output ovf
  );

endinterface

// File: rtl/dpll_id_counter.sv
// Increment/decrement counter (DCO): divides clk_in by 2*HALF_PERIOD and
// stretches or shrinks one half-period by a cycle per loop-filter request.
module dpll_id_counter
  import dpll_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  dpll_id_counter_if.slave bus
);

  localparam int unsigned CW = $clog2(HALF_PERIOD + 2);

  if (HALF_PERIOD < ID_HALF_PERIOD_MIN) begin : g_param_check
    $error("dpll_id_counter: HALF_PERIOD must be >= 2");
  end

  logic [CW-1:0] cnt, cnt_d;
  logic [CW-1:0] len, len_d;
  id_state_t     st, st_d, st_base;
  logic          id_out, id_out_d;
  logic          id_en, id_en_d;
  logic          ovf, ovf_d;
  logic          toggle_c;

  assign toggle_c = (cnt == len - CW'(1));

  // State register: counter, reload length, pending request and strobes.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      len    <= CW'(HALF_PERIOD);
      st     <= ID_IDLE;
      id_out <= 1'b0;
      id_en  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      cnt    <= cnt_d;
      len    <= len_d;
      st     <= st_d;
      id_out <= id_out_d;
      id_en  <= id_en_d;
      ovf    <= ovf_d;
    end
  end

  // Next state: a toggle consumes the pending request before new ones are merged,
  // so a request arriving on a toggle edge lands in the following half-period.
  always_comb begin
    cnt_d    = cnt + CW'(1);
    len_d    = len;
    id_out_d = id_out;
    id_en_d  = 1'b0;
    ovf_d    = 1'b0;
    st_base  = st;
    st_d     = st;

    if (toggle_c) begin
      cnt_d    = '0;
      id_out_d = ~id_out;
      id_en_d  = ~id_out;
      len_d    = CW'(id_reload_len(st, HALF_PERIOD));
      st_base  = ID_IDLE;
    end

    st_d = st_base;
    if (bus.inc ^ bus.dec) begin
      unique case (st_base)
        ID_IDLE: st_d = bus.inc ? ID_INC : ID_DEC;
        ID_INC: begin
          if (bus.dec) st_d = ID_IDLE;
          else         ovf_d = 1'b1;
        end
        ID_DEC: begin
          if (bus.inc) st_d = ID_IDLE;
          else         ovf_d = 1'b1;
        end
        default: st_d = ID_IDLE;
      endcase
    end
  end

  assign bus.id_out = id_out;
  assign bus.id_en  = id_en;
  assign bus.ovf    = ovf;

endmodule

// File: tb/tb_dpll_id_counter.sv
// Scenario-table bench for dpll_id_counter: expected half-period lengths and
// overflow cycles per scenario are expanded to per-cycle expectations.
module tb_dpll_id_counter;

  localparam int NCYC = 30;
  localparam int NHP  = 6;

  typedef struct {
    string name;
    int    inc_a;
    int    inc_b;
    int    dec_a;
    int    dec_b;
    int    hp[NHP];
    int    ovf_cyc;
  } vec_t;

  typedef struct {
    logic o;
    logic en;
    logic ov;
    int   cyc;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[9];

  dpll_id_counter_if bus ();

  dpll_id_counter #(.HALF_PERIOD(4)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #10 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input int ia, input int ib,
                              input int da, input int db,
                              input int h0, input int h1, input int h2,
                              input int h3, input int h4, input int h5,
                              input int oc);
    vec_t v;
    v.name = n; v.inc_a = ia; v.inc_b = ib; v.dec_a = da; v.dec_b = db;
    v.hp[0] = h0; v.hp[1] = h1; v.hp[2] = h2;
    v.hp[3] = h3; v.hp[4] = h4; v.hp[5] = h5;
    v.ovf_cyc = oc;
    return v;
  endfunction

  // Called at a falling edge just after reset release; cycle k is the k-th rising edge.
  task automatic run_vec(input vec_t v);
    int   next_tog;
    int   tidx;
    logic eo;
    exp_t e;
    exp_t got;
    next_tog = v.hp[0];
    tidx     = 0;
    eo       = 1'b0;
    for (int k = 1; k <= NCYC; k++) begin
      bus.inc = (k == v.inc_a) || (k == v.inc_b);
      bus.dec = (k == v.dec_a) || (k == v.dec_b);
      e.en = 1'b0;
      if (k == next_tog) begin
        eo   = ~eo;
        e.en = eo;
        tidx++;
        next_tog += (tidx < NHP) ? v.hp[tidx] : 4;
      end
      e.o   = eo;
      e.ov  = (k == v.ovf_cyc);
      e.cyc = k;
      sb.push_back(e);
      @(posedge clk_in);
      #1;
      got = sb.pop_front();
      chk($sformatf("%s c%0d id_out", v.name, got.cyc), int'(bus.id_out), int'(got.o));
      chk($sformatf("%s c%0d id_en", v.name, got.cyc), int'(bus.id_en), int'(got.en));
      chk($sformatf("%s c%0d ovf", v.name, got.cyc), int'(bus.ovf), int'(got.ov));
      @(negedge clk_in);
    end
    bus.inc = 1'b0;
    bus.dec = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n = 1'b0;
    #1;
    chk("reset id_out", int'(bus.id_out), 0);
    chk("reset id_en", int'(bus.id_en), 0);
    chk("reset ovf", int'(bus.ovf), 0);
    @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.inc = 1'b0;
    bus.dec = 1'b0;

    vecs[0] = mk("free",     -1, -1, -1, -1, 4, 4, 4, 4, 4, 4, -1);
    vecs[1] = mk("inc1",      6, -1, -1, -1, 4, 4, 3, 4, 4, 4, -1);
    vecs[2] = mk("dec1",     -1, -1,  6, -1, 4, 4, 5, 4, 4, 4, -1);
    vecs[3] = mk("incdec",    6, -1,  6, -1, 4, 4, 4, 4, 4, 4, -1);
    vecs[4] = mk("cancel",    5, -1,  7, -1, 4, 4, 4, 4, 4, 4, -1);
    vecs[5] = mk("inc_tog",   8, -1, -1, -1, 4, 4, 4, 3, 4, 4, -1);
    vecs[6] = mk("ovf_inc",   5,  7, -1, -1, 4, 4, 3, 4, 4, 4,  7);
    vecs[7] = mk("ovf_dec",  -1, -1,  2,  3, 4, 5, 4, 4, 4, 4,  3);
    vecs[8] = mk("max_rate",  2,  6, -1, -1, 4, 3, 3, 4, 4, 4, -1);

    #15;
    chk("por id_out", int'(bus.id_out), 0);
    chk("por id_en", int'(bus.id_en), 0);
    chk("por ovf", int'(bus.ovf), 0);
    #5;
    rst_n = 1'b1;
    run_vec(vecs[0]);

    for (int i = 1; i < 9; i++) begin
      do_reset();
      run_vec(vecs[i]);
    end

    // Asynchronous reset while id_out is high and a dec is pending.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      bus.dec = (k == 5);
      @(posedge clk_in);
      #1;
      @(negedge clk_in);
    end
    bus.dec = 1'b0;
    chk("midrst pre id_out", int'(bus.id_out), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst async id_out", int'(bus.id_out), 0);
    chk("midrst async id_en", int'(bus.id_en), 0);
    chk("midrst async ovf", int'(bus.ovf), 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    vecs[0].name = "after_rst";
    run_vec(vecs[0]);

    chk("scoreboard drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
